// File: rtl/let_stage_fifo_pkg.sv
// Shared defaults and helpers for the let_stage_fifo slice.
package let_stage_fifo_pkg;

  localparam int unsigned WIDTH_DEFAULT = 10;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Count must reach DEPTH itself, hence one bit more than the pointer.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/let_stage_fifo_if.sv
// Valid/ready handshake bundle between a producer/consumer and the FIFO stage.
interface let_stage_fifo_if
  import let_stage_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) ();

  logic                          i_valid;
  logic                          o_ready;
  logic [WIDTH-1:0]              i_data;
  logic                          o_valid;
  logic                          i_ready;
  logic [WIDTH-1:0]              o_data;
  logic [count_width(DEPTH)-1:0] o_count;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count
  );

endinterface

// File: rtl/let_stage_ptr.sv
// Wrapping FIFO pointer with synchronous clear and increment.
module let_stage_ptr
  import let_stage_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_inc,
  output logic [$clog2(DEPTH)-1:0] o_ptr
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clear) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/let_stage_fifo.sv
// Registered FIFO stage: valid/ready in and out, no fall-through, sync flush.
module let_stage_fifo
  import let_stage_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  let_stage_fifo_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  // Handshake flags depend on stored count only, so o_ready never sees i_ready.
  assign bus.o_ready = (count_q < CW'(DEPTH));
  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = mem_q[rd_ptr];
  assign bus.o_count = count_q;

  assign push = bus.i_valid & bus.o_ready;
  assign pop  = bus.o_valid & bus.i_ready;

  let_stage_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_inc   (push),
    .o_ptr   (wr_ptr)
  );

  let_stage_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_inc   (pop),
    .o_ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flush leaves contents alone; a push racing a flush is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !i_clear) begin
      mem_q[wr_ptr] <= bus.i_data;
    end
  end

endmodule

// File: tb/tb_let_stage_fifo.sv
// Directed self-checking bench for let_stage_fifo.
module tb_let_stage_fifo;

  logic clk;
  logic rst;
  logic clear;

  int n_pass;
  int n_total;

  let_stage_fifo_if #(.WIDTH(10), .DEPTH(4)) bus ();

  let_stage_fifo #(
    .WIDTH (10),
    .DEPTH (4)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (clear),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    #2;
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_ready", 32'(bus.o_ready), 1);
    chk("rst_data",  32'(bus.o_data),  0);
    tick();
    rst = 1'b0;

    // Three pushes with downstream stalled
    bus.i_valid = 1'b1;
    bus.i_data = 10'h001; tick();
    bus.i_data = 10'h002; tick();
    bus.i_data = 10'h3FF; tick();
    chk("fill3_count", 32'(bus.o_count), 3);
    chk("fill3_valid", 32'(bus.o_valid), 1);
    chk("fill3_data",  32'(bus.o_data),  10'h001);
    chk("fill3_ready", 32'(bus.o_ready), 1);

    // Fill to full, then an ignored fifth offer
    bus.i_data = 10'h004; tick();
    chk("full_count", 32'(bus.o_count), 4);
    chk("full_ready", 32'(bus.o_ready), 0);
    bus.i_data = 10'h0EE; tick();
    chk("full_ign_count", 32'(bus.o_count), 4);
    chk("full_ign_data",  32'(bus.o_data),  10'h001);

    // Pop from full and drain
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    chk("pop_full_count", 32'(bus.o_count), 3);
    chk("pop_full_ready", 32'(bus.o_ready), 1);
    chk("pop_full_data",  32'(bus.o_data),  10'h002);
    tick();
    chk("drain_data_3ff", 32'(bus.o_data), 10'h3FF);
    tick();
    chk("drain_data_004", 32'(bus.o_data), 10'h004);
    tick();
    chk("drain_empty_count", 32'(bus.o_count), 0);
    chk("drain_empty_valid", 32'(bus.o_valid), 0);
    tick();
    chk("pop_empty_count", 32'(bus.o_count), 0);

    // Steady streaming at count 2 across pointer wraps
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data = 10'h010; tick();
    bus.i_data = 10'h011; tick();
    chk("stream_pre_count", 32'(bus.o_count), 2);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.i_data = 10'(10'h012 + k);
      chk($sformatf("stream_head_%0d", k), 32'(bus.o_data), 32'(10'h010 + k));
      tick();
      chk($sformatf("stream_count_%0d", k), 32'(bus.o_count), 2);
    end
    chk("stream_head_end", 32'(bus.o_data), 10'h01A);
    bus.i_valid = 1'b0;
    tick();
    chk("stream_tail", 32'(bus.o_data), 10'h01B);
    chk("stream_tail_count", 32'(bus.o_count), 1);
    tick();
    chk("stream_drained", 32'(bus.o_count), 0);

    // No fall-through on an empty stage
    bus.i_valid = 1'b1;
    bus.i_data = 10'h155;
    chk("nft_valid_pre", 32'(bus.o_valid), 0);
    tick();
    bus.i_valid = 1'b0;
    chk("nft_valid_post", 32'(bus.o_valid), 1);
    chk("nft_data_post",  32'(bus.o_data),  10'h155);
    tick();
    chk("nft_popped_valid", 32'(bus.o_valid), 0);
    chk("nft_popped_count", 32'(bus.o_count), 0);

    // Clear wins over same-cycle push and pop
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data = 10'h0A1; tick();
    bus.i_data = 10'h0A2; tick();
    bus.i_data = 10'h0A3; tick();
    chk("clr_pre_count", 32'(bus.o_count), 3);
    clear = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_data = 10'h0A4;
    tick();
    clear = 1'b0;
    bus.i_ready = 1'b0;
    chk("clr_count", 32'(bus.o_count), 0);
    chk("clr_valid", 32'(bus.o_valid), 0);
    chk("clr_ready", 32'(bus.o_ready), 1);
    bus.i_data = 10'h0B1; tick();
    chk("clr_next_data",  32'(bus.o_data),  10'h0B1);
    chk("clr_next_count", 32'(bus.o_count), 1);
    bus.i_data = 10'h0B2; tick();
    bus.i_valid = 1'b0;
    chk("arst_pre_count", 32'(bus.o_count), 2);

    // Asynchronous reset between edges, push offered as reset releases
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 0);
    chk("arst_count", 32'(bus.o_count), 0);
    chk("arst_ready", 32'(bus.o_ready), 1);
    chk("arst_data",  32'(bus.o_data),  0);
    #1 rst = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data = 10'h0AA;
    tick();
    bus.i_valid = 1'b0;
    chk("arst_push_count", 32'(bus.o_count), 1);
    chk("arst_push_data",  32'(bus.o_data),  10'h0AA);
    bus.i_ready = 1'b1;
    tick();
    chk("arst_pop_count", 32'(bus.o_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/let_stage_fifo.md
LET_STAGE_FIFO -- requirements
Module: let_stage_fifo

Interface
REQ-001 Parameter WIDTH, default 10, payload width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 Port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port i_rst  input  1  asynchronous active-high reset.
REQ-005 Port i_clear  input  1  synchronous flush of all entries.
REQ-006 Port i_valid  input  1  upstream offers i_data.
REQ-007 Port o_ready  output  1  stage accepts a word this cycle.
REQ-008 Port i_data  input  WIDTH  upstream payload.
REQ-009 Port o_valid  output  1  head entry available downstream.
REQ-010 Port i_ready  input  1  downstream accepts the head entry.
REQ-011 Port o_data  output  WIDTH  head entry payload.
REQ-012 Port o_count  output  clog2(DEPTH)+1  number of stored entries.

Function
REQ-013 Push occurs when i_valid and o_ready are both 1 at a rising edge.
REQ-014 Pop occurs when o_valid and i_ready are both 1 at a rising edge.
REQ-015 o_ready is 1 exactly when o_count < DEPTH. It is combinational from stored state only and never depends on i_ready.
REQ-016 o_valid is 1 exactly when o_count > 0. There is no fall-through: a word pushed at edge N is first visible on o_data after edge N.
REQ-017 o_data equals the oldest stored entry; its value when o_valid is 0 is don't-care, but it is never X after reset.
REQ-018 Order is strictly FIFO.
REQ-019 Read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged and advances both pointers.
REQ-021 At count == 0, a pop cannot occur; a push alone gives count 1.
REQ-022 At count == DEPTH, a push cannot occur because o_ready is 0; a pop alone gives DEPTH-1, and o_ready is 1 in the following cycle.
REQ-023 i_valid without o_ready, and i_ready without o_valid, change no state.
REQ-024 i_clear sets count and both pointers to 0 at the next edge and takes priority over a same-cycle push or pop.
REQ-025 Storage contents are not cleared by i_clear.
REQ-026 o_count updates at the same edge as the push, pop or clear that changes it.

Reset
REQ-027 Asserting i_rst immediately, independent of i_clk, forces pointers and count to 0, o_valid to 0, o_ready to 1 and storage to 0.
REQ-028 Reset mid-transfer discards all stored words; the first push after deassertion is the next word delivered.
REQ-029 A push presented in the cycle i_rst deasserts is accepted normally at the next edge.

Structure
REQ-030 The shared package holds the WIDTH and DEPTH defaults and the count-width function.
REQ-031 One sub-module, let_stage_ptr, implements a wrapping pointer with increment and clear; it is instantiated twice, once for read and once for write.
REQ-032 Storage is a flat register array; no memory macro is used.

Verification
REQ-033 Reset, then push 0x001, 0x002, 0x3FF on consecutive cycles with i_ready=0 -> o_count=3, o_valid=1, o_data=0x001.
REQ-034 Push 4 words with i_ready=0 -> o_ready=0 and o_count=4; a fifth i_valid is ignored; one pop -> o_ready=1 next cycle and o_count=3.
REQ-035 From count 2, hold i_valid=i_ready=1 for 10 cycles with an incrementing payload -> o_count stays 2, order preserved across pointer wrap.
REQ-036 Empty stage, single push of 0x155 with i_ready=1 -> o_valid=0 in the push cycle; o_valid=1 with o_data=0x155 the next cycle; popped one cycle later.
REQ-037 Count 3 with i_clear, i_valid and i_ready all 1 -> o_count=0, o_valid=0 and o_ready=1 after the edge.
REQ-038 Assert i_rst between edges at count 2 -> o_valid=0 and o_count=0 before the next edge; a push of 0x0AA after deassertion is the next word out.
